// File: rtl/uart_pkg.sv
// Shared constants, state encoding and baud divider math for the UART blocks.
package uart_pkg;

    // Sample ticks per bit, and the tick indices used for mid-bit and end-of-bit decisions.
    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_SAMPLE = 4'd7;
    localparam logic [3:0] END_SAMPLE = 4'd15;

    // Receiver FSM encoding; values are fixed so the debug output is stable across builds.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest and never below 1.
    function automatic int calc_div(input int clk_freq, input int baud);
        int den;
        int q;
        den = baud * OVERSAMPLE;
        q   = (clk_freq + den / 2) / den;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; one-clock tick every DIV clocks.
// Never re-phased, so receivers see at most 1/16 bit of phase error.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             DIV  = calc_div(CLK_FREQ, BAUD);
    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling.
// Output handshake: rx_done and frame_err are one-clock strobes with no ready
// back-pressure; dout changes only on the edge that raises rx_done and holds
// until the next rx_done, so a consumer may capture it then or any time later.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int            NW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [NW-1:0] LAST_BIT = NW'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic                 w_fall;
    logic                 w_tick;

    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic [3:0]           r_s_cnt;
    logic [3:0]           w_s_cnt_next;
    logic [NW-1:0]        r_n;
    logic [NW-1:0]        w_n_next;
    logic [DATA_BITS-1:0] r_sh;
    logic [DATA_BITS-1:0] w_sh_next;
    logic [DATA_BITS-1:0] r_dout;
    logic [DATA_BITS-1:0] w_dout_next;
    logic                 r_done;
    logic                 w_done_next;
    logic                 r_ferr;
    logic                 w_ferr_next;

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Two-flop synchronizer plus one-cycle delayed copy for edge detection; idle is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    // Only a high->low transition starts a frame, so a held-low line never retriggers.
    assign w_fall = r_rx_prev & ~r_rx_s;

    // Next-state and datapath decisions; everything holds unless a tick or start edge says otherwise.
    always_comb begin
        w_state_next = r_state;
        w_s_cnt_next = r_s_cnt;
        w_n_next     = r_n;
        w_sh_next    = r_sh;
        w_dout_next  = r_dout;
        w_done_next  = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_next = ST_START;
                    w_s_cnt_next = 4'd0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s_cnt == MID_SAMPLE) begin
                        if (!r_rx_s) begin
                            w_state_next = ST_DATA;
                            w_s_cnt_next = 4'd0;
                            w_n_next     = '0;
                        end else begin
                            // Line back high at mid start bit: glitch, drop silently.
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s_cnt == END_SAMPLE) begin
                        w_sh_next    = {r_rx_s, r_sh[DATA_BITS-1:1]};
                        w_s_cnt_next = 4'd0;
                        if (r_n == LAST_BIT) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_n_next = r_n + NW'(1);
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s_cnt == END_SAMPLE) begin
                        // Mid stop bit: returning to IDLE here leaves half a bit to catch the next start.
                        if (r_rx_s) begin
                            w_dout_next = r_sh;
                            w_done_next = 1'b1;
                        end else begin
                            w_ferr_next = 1'b1;
                        end
                        w_state_next = ST_IDLE;
                        w_s_cnt_next = 4'd0;
                    end else begin
                        w_s_cnt_next = r_s_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counters, shift register, output byte and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_cnt <= 4'd0;
            r_n     <= '0;
            r_sh    <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_s_cnt <= w_s_cnt_next;
            r_n     <= w_n_next;
            r_sh    <= w_sh_next;
            r_dout  <= w_dout_next;
            r_done  <= w_done_next;
            r_ferr  <= w_ferr_next;
        end
    end

    assign dout      = r_dout;
    assign rx_done   = r_done;
    assign frame_err = r_ferr;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule
